// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: access-size mask encodings,
// the transaction state enum and the byte-enable helper.
package lsu_pkg;

    // Access masks: bits [1:0] give the size, bit 2 selects zero-extension.
    localparam logic [2:0] MASK_B  = 3'b000;
    localparam logic [2:0] MASK_H  = 3'b001;
    localparam logic [2:0] MASK_W  = 3'b010;
    localparam logic [2:0] MASK_BU = 3'b100;
    localparam logic [2:0] MASK_HU = 3'b101;

    typedef enum logic [1:0] {IDLE, REQ, WAIT_R, RESP} state_t;

    // Byte enables for a legal access; halves are lane-aligned on addr[1].
    function automatic logic [3:0] byte_en(input logic [2:0] mask, input logic [1:0] addr);
        case (mask[1:0])
            MASK_B[1:0]: byte_en = 4'b0001 << addr;
            MASK_H[1:0]: byte_en = 4'b0011 << {addr[1], 1'b0};
            default:     byte_en = 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/lsu_if.sv
// Core-request, response and data-memory signals of the load/store unit.
//   master : the LSU's view (accepts requests, returns responses, drives memory)
//   slave  : the environment's view (execute/writeback stages plus memory)
interface lsu_if #(parameter int ADDR_W = 32);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [2:0]        req_mask;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic              resp_ready;
    logic [31:0]       resp_rdata;
    logic              resp_err;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [3:0]        mem_be;
    logic [31:0]       mem_wdata;
    logic              mem_gnt;
    logic              mem_rvalid;
    logic [31:0]       mem_rdata;

    modport master (
        input  req_valid, req_we, req_mask, req_addr, req_wdata, resp_ready,
               mem_gnt, mem_rvalid, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err,
               mem_req, mem_we, mem_addr, mem_be, mem_wdata
    );

    modport slave (
        output req_valid, req_we, req_mask, req_addr, req_wdata, resp_ready,
               mem_gnt, mem_rvalid, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err,
               mem_req, mem_we, mem_addr, mem_be, mem_wdata
    );
endinterface

// File: rtl/lsu_load_align.sv
// Load data alignment: picks the addressed byte/half out of the read word
// and sign- or zero-extends it to 32 bits.
//   rdata : word returned by memory
//   addr  : byte offset within the word
//   mask  : access mask (size in [1:0], unsigned in [2])
//   data  : extended result
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr,
    input  logic [2:0]  mask,
    output logic [31:0] data
);
    logic [7:0]  b;
    logic [15:0] h;

    always_comb begin
        b    = rdata[{addr, 3'b000} +: 8];
        h    = addr[1] ? rdata[31:16] : rdata[15:0];
        data = rdata;
        case (mask[1:0])
            MASK_B[1:0]: data = {{24{b[7] & ~mask[2]}}, b};
            MASK_H[1:0]: data = {{16{h[15] & ~mask[2]}}, h};
            default:     data = rdata;
        endcase
    end
endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one request at a time, rejects illegal ones
// without touching memory, drives the word-addressed memory port and
// returns extended load data or an error, with a bounded wait in REQ/WAIT_R.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : lsu_if.master (core request/response + memory port)
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 16
) (
    input logic   clk,
    input logic   rst_n,
    lsu_if.master bus
);
    state_t            state, state_nx;
    logic              we_q;
    logic [2:0]        mask_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       rdata_q;
    logic              err_q;
    logic [7:0]        cnt_q;
    logic              illegal;
    logic              tmo;
    logic [31:0]       load_ext;

    // Legality is judged on the incoming request, before capture.
    always_comb begin
        illegal = 1'b0;
        case (bus.req_mask)
            MASK_B, MASK_BU: illegal = bus.req_mask[2] & bus.req_we;
            MASK_H, MASK_HU: illegal = (bus.req_mask[2] & bus.req_we) | bus.req_addr[0];
            MASK_W:          illegal = |bus.req_addr[1:0];
            default:         illegal = 1'b1;
        endcase
    end

    // Last allowed cycle in REQ/WAIT_R: the counter started at 0 on entry.
    assign tmo = (cnt_q == 8'(TIMEOUT - 1));

    lsu_load_align u_align (
        .rdata (bus.mem_rdata),
        .addr  (addr_q[1:0]),
        .mask  (mask_q),
        .data  (load_ext)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx       = state;
        bus.req_ready  = 1'b0;
        bus.resp_valid = 1'b0;
        bus.resp_rdata = '0;
        bus.resp_err   = 1'b0;
        bus.mem_req    = 1'b0;
        bus.mem_we     = 1'b0;
        bus.mem_addr   = '0;
        bus.mem_be     = '0;
        bus.mem_wdata  = '0;
        case (state)
            IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) state_nx = illegal ? RESP : REQ;
            end
            REQ: begin
                bus.mem_req  = 1'b1;
                bus.mem_we   = we_q;
                bus.mem_addr = {addr_q[ADDR_W-1:2], 2'b00};
                bus.mem_be   = byte_en(mask_q, addr_q[1:0]);
                case (mask_q[1:0])
                    MASK_B[1:0]: bus.mem_wdata = {4{wdata_q[7:0]}};
                    MASK_H[1:0]: bus.mem_wdata = {2{wdata_q[15:0]}};
                    default:     bus.mem_wdata = wdata_q;
                endcase
                if (bus.mem_gnt)  state_nx = we_q ? RESP : WAIT_R;
                else if (tmo)     state_nx = RESP;
            end
            WAIT_R: begin
                if (bus.mem_rvalid || tmo) state_nx = RESP;
            end
            RESP: begin
                bus.resp_valid = 1'b1;
                bus.resp_rdata = rdata_q;
                bus.resp_err   = err_q;
                if (bus.resp_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // rdata_q/err_q are cleared at accept so a store or a timeout returns 0.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            we_q    <= 1'b0;
            mask_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            case (state)
                IDLE: if (bus.req_valid) begin
                    we_q    <= bus.req_we;
                    mask_q  <= bus.req_mask;
                    addr_q  <= bus.req_addr;
                    wdata_q <= bus.req_wdata;
                    rdata_q <= '0;
                    err_q   <= illegal;
                    cnt_q   <= '0;
                end
                REQ: begin
                    if (bus.mem_gnt) cnt_q <= '0;
                    else if (tmo)    err_q <= 1'b1;
                    else             cnt_q <= cnt_q + 8'd1;
                end
                WAIT_R: begin
                    if (bus.mem_rvalid) rdata_q <= load_ext;
                    else if (tmo)       err_q   <= 1'b1;
                    else                cnt_q   <= cnt_q + 8'd1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: a transaction-level model predicts
// the cycle-by-cycle timeline of each request; one compare process checks the
// DUT against it every cycle.
module tb_load_store_unit;
    localparam int TO = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    lsu_if #(.ADDR_W(32)) bus();

    load_store_unit #(.ADDR_W(32), .TIMEOUT(TO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    int n_vec  = 0;
    int n_fail = 0;

    logic        chk_on = 1'b0;
    logic        e_ready, e_mreq, e_mwe, e_rv, e_err;
    logic [31:0] e_maddr, e_wd, e_rdata;
    logic [3:0]  e_be;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic int msize(input logic [2:0] m);
        case (m)
            3'b000, 3'b100: return 1;
            3'b001, 3'b101: return 2;
            3'b010:         return 4;
            default:        return 0;
        endcase
    endfunction

    function automatic logic legal(input logic we, input logic [2:0] m, input logic [31:0] a);
        int sz = msize(m);
        if (sz == 0) return 1'b0;
        if (m[2] && we) return 1'b0;
        return (int'(a[1:0]) % sz) == 0;
    endfunction

    function automatic logic [3:0] m_be(input logic [2:0] m, input logic [31:0] a);
        int v = ((1 << msize(m)) - 1) << a[1:0];
        return v[3:0];
    endfunction

    function automatic logic [31:0] m_wrep(input logic [2:0] m, input logic [31:0] wd);
        case (msize(m))
            1:       return wd[7:0] * 32'h01010101;
            2:       return wd[15:0] * 32'h00010001;
            default: return wd;
        endcase
    endfunction

    function automatic logic [31:0] m_ext(input logic [2:0] m, input logic [31:0] a, input logic [31:0] word);
        int     sz = msize(m);
        longint v  = longint'(word) >> (8 * int'(a[1:0]));
        if (sz < 4) begin
            v = v & ((longint'(1) << (8 * sz)) - 1);
            if (!m[2] && v[8*sz-1]) v = v - (longint'(1) << (8 * sz));
        end
        return v[31:0];
    endfunction

    // ---------------- compare process ----------------
    always @(posedge clk) begin
        #1;
        if (chk_on) begin
            chk("req_ready",  32'(bus.req_ready),  32'(e_ready));
            chk("mem_req",    32'(bus.mem_req),    32'(e_mreq));
            chk("resp_valid", 32'(bus.resp_valid), 32'(e_rv));
            if (e_mreq) begin
                chk("mem_addr",  bus.mem_addr,      e_maddr);
                chk("mem_be",    32'(bus.mem_be),   32'(e_be));
                chk("mem_wdata", bus.mem_wdata,     e_wd);
                chk("mem_we",    32'(bus.mem_we),   32'(e_mwe));
            end
            if (e_rv) begin
                chk("resp_rdata", bus.resp_rdata,    e_rdata);
                chk("resp_err",   32'(bus.resp_err), 32'(e_err));
            end
        end
    end

    task automatic set_idle_exp();
        e_ready = 1'b1;
        e_mreq  = 1'b0;
        e_rv    = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            bus.req_valid  = 1'b0;
            bus.mem_gnt    = 1'($urandom_range(0, 1));
            bus.mem_rvalid = 1'($urandom_range(0, 1));
            bus.mem_rdata  = $urandom;
            bus.resp_ready = 1'($urandom_range(0, 1));
            set_idle_exp();
            @(negedge clk);
        end
    endtask

    // One transaction. g: cycles of mem_req before gnt, r: WAIT_R cycles
    // before rvalid (>= TO means never), d: cycles resp_ready held low.
    task automatic run_txn(input logic we, input logic [2:0] m, input logic [31:0] a,
                           input logic [31:0] wd, input logic [31:0] word,
                           input int g, input int r, input int d);
        logic ok, granted, ldw, rok;
        int   n_req, n_w, s, k;
        ok      = legal(we, m, a);
        granted = ok && (g < TO);
        ldw     = granted && !we;
        rok     = r < TO;
        n_req   = ok ? ((g < TO) ? g + 1 : TO) : 0;
        n_w     = ldw ? (rok ? r + 1 : TO) : 0;
        s       = n_req + n_w + 1;
        for (int c = 0; c <= s + d; c++) begin
            if (c == 0) begin
                bus.req_valid = 1'b1;
                bus.req_we    = we;
                bus.req_mask  = m;
                bus.req_addr  = a;
                bus.req_wdata = wd;
            end else begin
                bus.req_valid = 1'($urandom_range(0, 1));
                bus.req_we    = 1'($urandom_range(0, 1));
                bus.req_mask  = 3'($urandom);
                bus.req_addr  = $urandom;
                bus.req_wdata = $urandom;
            end
            bus.mem_gnt = granted && (c == g + 1);
            if (ldw && rok && c == n_req + r + 1) begin
                bus.mem_rvalid = 1'b1;
                bus.mem_rdata  = word;
            end else if (ldw && c > n_req && c < s) begin
                bus.mem_rvalid = 1'b0;
                bus.mem_rdata  = $urandom;
            end else begin
                bus.mem_rvalid = 1'($urandom_range(0, 1));
                bus.mem_rdata  = $urandom;
            end
            bus.resp_ready = (c == s + d) ? 1'b1 : (c < s ? 1'($urandom_range(0, 1)) : 1'b0);
            k       = c + 1;
            e_mreq  = (k <= n_req);
            e_ready = (k == s + d + 1);
            e_rv    = (k >= s) && (k <= s + d);
            e_maddr = {a[31:2], 2'b00};
            e_be    = m_be(m, a);
            e_wd    = m_wrep(m, wd);
            e_mwe   = we;
            e_rdata = (ldw && rok) ? m_ext(m, a, word) : 32'h0;
            e_err   = !ok || !granted || (ldw && !rok);
            @(negedge clk);
        end
        bus.req_valid  = 1'b0;
        bus.resp_ready = 1'b0;
        bus.mem_gnt    = 1'b0;
        bus.mem_rvalid = 1'b0;
    endtask

    initial begin
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_mask   = '0;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;
        bus.resp_ready = 1'b0;
        bus.mem_gnt    = 1'b0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = '0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_req_ready",  32'(bus.req_ready),  32'h1);
        chk("rst_mem_req",    32'(bus.mem_req),    32'h0);
        chk("rst_resp_valid", 32'(bus.resp_valid), 32'h0);
        chk("rst_resp_err",   32'(bus.resp_err),   32'h0);
        chk("rst_resp_rdata", bus.resp_rdata,      32'h0);
        chk("rst_mem_be",     32'(bus.mem_be),     32'h0);
        rst_n = 1'b1;

        // Hand-computed values pinning the model.
        chk("model_be_b103",   32'(m_be(3'b000, 32'h103)),      32'h8);
        chk("model_wrep_b",    m_wrep(3'b000, 32'h000000AB),    32'hABABABAB);
        chk("model_ext_b",     m_ext(3'b000, 32'h102, 32'h00F30000), 32'hFFFFFFF3);
        chk("model_ext_bu",    m_ext(3'b100, 32'h102, 32'h00F30000), 32'h000000F3);
        chk("model_ext_h",     m_ext(3'b001, 32'h206, 32'h80010000), 32'hFFFF8001);
        chk("model_legal_w",   32'(legal(1'b0, 3'b010, 32'h101)), 32'h0);
        chk("model_legal_bus", 32'(legal(1'b1, 3'b100, 32'h100)), 32'h0);

        set_idle_exp();
        chk_on = 1'b1;
        idle(1);

        // Directed cases.
        run_txn(1'b1, 3'b000, 32'h103, 32'h000000AB, 32'h0, 0, 0, 0);
        run_txn(1'b0, 3'b000, 32'h102, 32'h0, 32'h00F30000, 0, 0, 0);
        run_txn(1'b0, 3'b100, 32'h102, 32'h0, 32'h00F30000, 0, 0, 0);
        run_txn(1'b0, 3'b001, 32'h206, 32'h0, 32'h80010000, 3, 0, 0);
        run_txn(1'b0, 3'b010, 32'h101, 32'h0, 32'h0, 0, 0, 0);
        run_txn(1'b1, 3'b100, 32'h100, 32'h55, 32'h0, 0, 0, 0);
        run_txn(1'b0, 3'b010, 32'h300, 32'h0, 32'h12345678, 0, TO, 3);
        idle(2);
        run_txn(1'b0, 3'b010, 32'h304, 32'h0, 32'h89ABCDEF, 0, 0, 0);
        run_txn(1'b1, 3'b001, 32'h10A, 32'h0000BEEF, 32'h0, TO + 1, 0, 1);
        run_txn(1'b0, 3'b010, 32'h400, 32'h0, 32'hCAFEBABE, 0, 0, 5);

        // Reset while a store sits in REQ: abandoned, no response.
        chk_on         = 1'b0;
        bus.req_valid  = 1'b1;
        bus.req_we     = 1'b1;
        bus.req_mask   = 3'b010;
        bus.req_addr   = 32'h500;
        bus.req_wdata  = 32'h11223344;
        bus.mem_gnt    = 1'b0;
        bus.resp_ready = 1'b1;
        @(negedge clk);
        chk("mid_mem_req", 32'(bus.mem_req), 32'h1);
        bus.req_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("mid_rst_req_ready",  32'(bus.req_ready),  32'h1);
        chk("mid_rst_mem_req",    32'(bus.mem_req),    32'h0);
        chk("mid_rst_resp_valid", 32'(bus.resp_valid), 32'h0);
        set_idle_exp();
        chk_on = 1'b1;
        idle(3);

        // Randomized traffic.
        for (int i = 0; i < 300; i++) begin
            logic [31:0] a;
            a = $urandom;
            run_txn(1'($urandom_range(0, 1)), 3'($urandom), a, $urandom, $urandom,
                    $urandom_range(0, TO + 1), $urandom_range(0, TO + 1), $urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        end

        chk_on = 1'b0;
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
